anabellek_yazma_tamponu: RTL and testbench

- Posted write buffer between the direct-mapped cache's main-memory port and the main memory model.
- Absorbs 128-bit line write-backs into a small FIFO, so cache evictions do not stall on memory latency.
- Coalesces repeated writes to the same line.
- Serves reads that hit a buffered line directly from the FIFO; sends read misses to memory ahead of queued writes.

---
 rtl/anabellek_yazma_tamponu.sv | 200 ++++++++++++++++++++
 tb/tb_anabellek_yazma_tamponu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_yazma_tamponu.sv
`default_nettype none
// ============================================================================
// anabellek_yazma_tamponu : posted line write buffer with coalescing and
//                           read forwarding in front of main memory
// Rev 1.0
// ============================================================================
module anabellek_yazma_tamponu #(
  parameter int DERINLIK  = 4,
  parameter int VERI_BIT  = 128,
  parameter int ADRES_BIT = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ADRES_BIT-1:0]            ust_istek_adres_i,
  input  logic [VERI_BIT-1:0]             ust_istek_veri_i,
  input  logic                            ust_istek_gecerli_i,
  input  logic                            ust_istek_yaz_gecerli_i,
  output logic                            ust_istek_hazir_o,
  output logic [VERI_BIT-1:0]             ust_yanit_veri_o,
  output logic                            ust_yanit_gecerli_o,
  input  logic                            ust_yanit_hazir_i,
  output logic [ADRES_BIT-1:0]            alt_istek_adres_o,
  output logic [VERI_BIT-1:0]             alt_istek_veri_o,
  output logic                            alt_istek_gecerli_o,
  output logic                            alt_istek_yaz_gecerli_o,
  input  logic                            alt_istek_hazir_i,
  input  logic [VERI_BIT-1:0]             alt_yanit_veri_i,
  input  logic                            alt_yanit_gecerli_i,
  output logic                            alt_yanit_hazir_o,
  output logic [$clog2(DERINLIK+1)-1:0]   doluluk_o
);

  localparam int c_IW = $clog2(DERINLIK);
  localparam int c_CW = $clog2(DERINLIK+1);
  localparam int c_HW = ADRES_BIT - 4;

  typedef enum logic [1:0] {BOS, OKU_GONDER, OKU_BEKLE, YANIT} durum_t;

  durum_t              r_durum, w_durum_sonraki;

  logic [c_HW-1:0]     r_satir_adr  [DERINLIK];
  logic [VERI_BIT-1:0] r_satir_veri [DERINLIK];
  logic [c_IW-1:0]     r_bas, r_kuyruk;
  logic [c_CW-1:0]     r_sayi;
  logic                r_alt_gecerli, r_alt_yaz;
  logic [c_HW-1:0]     r_oku_adr;
  logic [VERI_BIT-1:0] r_yanit_veri;

  logic [c_HW-1:0]     w_istek_satir;
  logic                w_bas_sunuluyor, w_dolu;
  logic                w_yaz_es, w_oku_es;
  logic [c_IW-1:0]     w_yaz_idx, w_oku_idx;
  logic                w_ust_el, w_yaz_kabul, w_oku_kabul, w_push;
  logic                w_alt_el, w_pop, w_sun_yaz, w_sun_oku;
  logic                w_unused_adr_lsb;

  assign w_istek_satir    = ust_istek_adres_i[ADRES_BIT-1:4];
  assign w_unused_adr_lsb = ^ust_istek_adres_i[3:0];
  assign w_bas_sunuluyor  = r_alt_gecerli && r_alt_yaz;
  assign w_dolu           = (r_sayi == c_CW'(DERINLIK));

  // Oldest-to-youngest scan: the last hit is the youngest copy of the line.
  // The presented head is frozen, so writes may not coalesce into it.
  always_comb begin
    w_yaz_es  = 1'b0;
    w_yaz_idx = '0;
    w_oku_es  = 1'b0;
    w_oku_idx = '0;
    for (int k = 0; k < DERINLIK; k++) begin
      if ((c_CW'(k) < r_sayi) && (r_satir_adr[r_bas + c_IW'(k)] == w_istek_satir)) begin
        w_oku_es  = 1'b1;
        w_oku_idx = r_bas + c_IW'(k);
        if (!((k == 0) && w_bas_sunuluyor)) begin
          w_yaz_es  = 1'b1;
          w_yaz_idx = r_bas + c_IW'(k);
        end
      end
    end
  end

  assign w_ust_el    = ust_istek_gecerli_i && ust_istek_hazir_o;
  assign w_yaz_kabul = w_ust_el && ust_istek_yaz_gecerli_i;
  assign w_oku_kabul = w_ust_el && !ust_istek_yaz_gecerli_i;
  assign w_push      = w_yaz_kabul && !w_yaz_es;
  assign w_alt_el    = r_alt_gecerli && alt_istek_hazir_i;
  assign w_pop       = w_alt_el && r_alt_yaz;

  // A read miss accepted this cycle claims the next downstream slot.
  assign w_sun_oku = !r_alt_gecerli && (r_durum == OKU_GONDER);
  assign w_sun_yaz = !r_alt_gecerli && (r_sayi != '0) &&
                     ((r_durum == YANIT) ||
                      ((r_durum == BOS) && !(w_oku_kabul && !w_oku_es)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
    end else begin
      r_durum <= w_durum_sonraki;
    end
  end

  always_comb begin
    w_durum_sonraki     = r_durum;
    ust_istek_hazir_o   = 1'b0;
    ust_yanit_gecerli_o = 1'b0;
    alt_yanit_hazir_o   = 1'b0;
    case (r_durum)
      BOS: begin
        ust_istek_hazir_o = !rst_i && (!ust_istek_yaz_gecerli_i || !w_dolu || w_yaz_es);
        if (ust_istek_gecerli_i && ust_istek_hazir_o && !ust_istek_yaz_gecerli_i) begin
          w_durum_sonraki = w_oku_es ? YANIT : OKU_GONDER;
        end
      end
      OKU_GONDER: begin
        if (w_alt_el && !r_alt_yaz) begin
          w_durum_sonraki = OKU_BEKLE;
        end
      end
      OKU_BEKLE: begin
        alt_yanit_hazir_o = 1'b1;
        if (alt_yanit_gecerli_i) begin
          w_durum_sonraki = YANIT;
        end
      end
      YANIT: begin
        ust_yanit_gecerli_o = 1'b1;
        if (ust_yanit_hazir_i) begin
          w_durum_sonraki = BOS;
        end
      end
      default: w_durum_sonraki = BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bas         <= '0;
      r_kuyruk      <= '0;
      r_sayi        <= '0;
      r_alt_gecerli <= 1'b0;
      r_alt_yaz     <= 1'b0;
      r_oku_adr     <= '0;
      r_yanit_veri  <= '0;
    end else begin
      if (w_push) begin
        r_kuyruk <= r_kuyruk + 1'b1;
      end
      if (w_pop) begin
        r_bas <= r_bas + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_sayi <= r_sayi + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_sayi <= r_sayi - c_CW'(1);
      end

      if (w_alt_el) begin
        r_alt_gecerli <= 1'b0;
      end else if (w_sun_oku) begin
        r_alt_gecerli <= 1'b1;
        r_alt_yaz     <= 1'b0;
      end else if (w_sun_yaz) begin
        r_alt_gecerli <= 1'b1;
        r_alt_yaz     <= 1'b1;
      end

      if (w_oku_kabul && !w_oku_es) begin
        r_oku_adr <= w_istek_satir;
      end
      if (w_oku_kabul && w_oku_es) begin
        r_yanit_veri <= r_satir_veri[w_oku_idx];
      end else if ((r_durum == OKU_BEKLE) && alt_yanit_gecerli_i) begin
        r_yanit_veri <= alt_yanit_veri_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_yaz_kabul) begin
      if (w_yaz_es) begin
        r_satir_veri[w_yaz_idx] <= ust_istek_veri_i;
      end else begin
        r_satir_adr[r_kuyruk]  <= w_istek_satir;
        r_satir_veri[r_kuyruk] <= ust_istek_veri_i;
      end
    end
  end

  // Write address/data come straight from the head slot, which is immutable
  // while presented, so they stay stable through the handshake.
  assign alt_istek_gecerli_o     = r_alt_gecerli;
  assign alt_istek_yaz_gecerli_o = r_alt_gecerli && r_alt_yaz;
  assign alt_istek_adres_o       = !r_alt_gecerli ? '0 :
                                   {(r_alt_yaz ? r_satir_adr[r_bas] : r_oku_adr), 4'b0000};
  assign alt_istek_veri_o        = (r_alt_gecerli && r_alt_yaz) ? r_satir_veri[r_bas] : '0;
  assign ust_yanit_veri_o        = r_yanit_veri;
  assign doluluk_o               = r_sayi;

endmodule
`default_nettype wire

// File: tb/tb_anabellek_yazma_tamponu.sv
`default_nettype none
// ============================================================================
// tb_anabellek_yazma_tamponu : directed self-checking bench for the write buffer
// Rev 1.0
// ============================================================================
module tb_anabellek_yazma_tamponu;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  ust_istek_adres_i;
  logic [127:0] ust_istek_veri_i;
  logic         ust_istek_gecerli_i;
  logic         ust_istek_yaz_gecerli_i;
  logic         ust_istek_hazir_o;
  logic [127:0] ust_yanit_veri_o;
  logic         ust_yanit_gecerli_o;
  logic         ust_yanit_hazir_i;
  logic [31:0]  alt_istek_adres_o;
  logic [127:0] alt_istek_veri_o;
  logic         alt_istek_gecerli_o;
  logic         alt_istek_yaz_gecerli_o;
  logic         alt_istek_hazir_i;
  logic [127:0] alt_yanit_veri_i;
  logic         alt_yanit_gecerli_i;
  logic         alt_yanit_hazir_o;
  logic [2:0]   doluluk_o;

  int n_kontrol = 0;
  int n_hata    = 0;

  localparam logic [127:0] VA = {4{32'hA0A0_0001}};
  localparam logic [127:0] VB = {4{32'hB0B0_0002}};
  localparam logic [127:0] VC = {4{32'hC0C0_0003}};
  localparam logic [127:0] VD = {4{32'hD0D0_0004}};
  localparam logic [127:0] VE = {4{32'hE0E0_0005}};
  localparam logic [127:0] VX = {4{32'h5A5A_0006}};
  localparam logic [127:0] W0 = {4{32'h1111_0000}};
  localparam logic [127:0] W1 = {4{32'h2222_0001}};
  localparam logic [127:0] W3 = {4{32'h4444_0003}};

  logic [127:0] veri_tab [4];

  anabellek_yazma_tamponu #(
    .DERINLIK(4), .VERI_BIT(128), .ADRES_BIT(32)
  ) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .ust_istek_adres_i       (ust_istek_adres_i),
    .ust_istek_veri_i        (ust_istek_veri_i),
    .ust_istek_gecerli_i     (ust_istek_gecerli_i),
    .ust_istek_yaz_gecerli_i (ust_istek_yaz_gecerli_i),
    .ust_istek_hazir_o       (ust_istek_hazir_o),
    .ust_yanit_veri_o        (ust_yanit_veri_o),
    .ust_yanit_gecerli_o     (ust_yanit_gecerli_o),
    .ust_yanit_hazir_i       (ust_yanit_hazir_i),
    .alt_istek_adres_o       (alt_istek_adres_o),
    .alt_istek_veri_o        (alt_istek_veri_o),
    .alt_istek_gecerli_o     (alt_istek_gecerli_o),
    .alt_istek_yaz_gecerli_o (alt_istek_yaz_gecerli_o),
    .alt_istek_hazir_i       (alt_istek_hazir_i),
    .alt_yanit_veri_i        (alt_yanit_veri_i),
    .alt_yanit_gecerli_i     (alt_yanit_gecerli_i),
    .alt_yanit_hazir_o       (alt_yanit_hazir_o),
    .doluluk_o               (doluluk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen,
                         input logic [127:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic istek(input logic [31:0] adres, input logic [127:0] veri, input logic yaz);
    ust_istek_gecerli_i     = 1'b1;
    ust_istek_adres_i       = adres;
    ust_istek_veri_i        = veri;
    ust_istek_yaz_gecerli_i = yaz;
  endtask

  task automatic birak();
    ust_istek_gecerli_i     = 1'b0;
    ust_istek_yaz_gecerli_i = 1'b0;
  endtask

  initial begin
    veri_tab[0] = W0; veri_tab[1] = W1; veri_tab[2] = VC; veri_tab[3] = W3;
    rst_i = 1'b1;
    ust_istek_adres_i = '0; ust_istek_veri_i = '0;
    ust_istek_gecerli_i = 1'b0; ust_istek_yaz_gecerli_i = 1'b0;
    ust_yanit_hazir_i = 1'b1;
    alt_istek_hazir_i = 1'b0; alt_yanit_veri_i = '0; alt_yanit_gecerli_i = 1'b0;

    repeat (10) adim();
    kontrol("rst_doluluk", doluluk_o, 0);
    kontrol("rst_alt_gecerli", alt_istek_gecerli_o, 0);
    kontrol("rst_yanit_gecerli", ust_yanit_gecerli_o, 0);
    kontrol("rst_hazir", ust_istek_hazir_o, 0);
    rst_i = 1'b0;

    // single write drains one cycle after acceptance
    alt_istek_hazir_i = 1'b1;
    istek(32'h100, VA, 1'b1); #1;
    kontrol("t1_hazir", ust_istek_hazir_o, 1);
    adim(); birak();
    kontrol("t1_doluluk1", doluluk_o, 1);
    kontrol("t1_alt_henuz", alt_istek_gecerli_o, 0);
    adim();
    kontrol("t1_alt_gecerli", alt_istek_gecerli_o, 1);
    kontrol("t1_alt_yaz", alt_istek_yaz_gecerli_o, 1);
    kontrol("t1_alt_adres", alt_istek_adres_o, 32'h100);
    kontrol("t1_alt_veri", alt_istek_veri_o, VA);
    adim();
    kontrol("t1_doluluk0", doluluk_o, 0);
    kontrol("t1_alt_bitti", alt_istek_gecerli_o, 0);

    // fill, full back-pressure, coalescing
    alt_istek_hazir_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      istek(32'(i * 16), veri_tab[i], 1'b1); #1;
      kontrol("t2_doldur_hazir", ust_istek_hazir_o, 1);
      adim();
    end
    birak();
    kontrol("t2_doluluk4", doluluk_o, 4);
    istek(32'h040, VX, 1'b1); #1;
    kontrol("t2_dolu_hazir", ust_istek_hazir_o, 0);
    istek(32'h000, VX, 1'b1); #1;
    kontrol("t2_bas_sunulu_hazir", ust_istek_hazir_o, 0);
    istek(32'h010, VB, 1'b1); #1;
    kontrol("t2_birlesim_hazir", ust_istek_hazir_o, 1);
    adim(); birak();
    kontrol("t2_birlesim_doluluk", doluluk_o, 4);

    // read hit forwarded from buffer
    istek(32'h024, '0, 1'b0); #1;
    kontrol("t3_hazir", ust_istek_hazir_o, 1);
    adim(); birak();
    kontrol("t3_yanit_gecerli", ust_yanit_gecerli_o, 1);
    kontrol("t3_yanit_veri", ust_yanit_veri_o, VC);
    kontrol("t3_alt_yaz", alt_istek_yaz_gecerli_o, 1);
    kontrol("t3_alt_adres", alt_istek_adres_o, 32'h000);
    adim();
    kontrol("t3_yanit_bitti", ust_yanit_gecerli_o, 0);

    // read miss overtakes queued writes
    alt_istek_hazir_i = 1'b1;
    kontrol("t4_bas_veri", alt_istek_veri_o, W0);
    adim(); alt_istek_hazir_i = 1'b0;
    kontrol("t4_doluluk3", doluluk_o, 3);
    adim();
    kontrol("t4_b_adres", alt_istek_adres_o, 32'h010);
    kontrol("t4_b_veri", alt_istek_veri_o, VB);
    istek(32'h500, '0, 1'b0); #1;
    kontrol("t4_oku_hazir", ust_istek_hazir_o, 1);
    adim(); birak();
    kontrol("t4_yazma_suruyor", alt_istek_yaz_gecerli_o, 1);
    alt_istek_hazir_i = 1'b1;
    adim();
    kontrol("t4_doluluk2", doluluk_o, 2);
    kontrol("t4_bosluk", alt_istek_gecerli_o, 0);
    adim();
    kontrol("t4_oku_gecerli", alt_istek_gecerli_o, 1);
    kontrol("t4_oku_yaz", alt_istek_yaz_gecerli_o, 0);
    kontrol("t4_oku_adres", alt_istek_adres_o, 32'h500);
    ust_yanit_hazir_i = 1'b0;
    adim(); alt_istek_hazir_i = 1'b0;
    kontrol("t4_alt_yanit_hazir", alt_yanit_hazir_o, 1);
    repeat (4) adim();
    kontrol("t4_bekle_drenaj_yok", alt_istek_gecerli_o, 0);
    kontrol("t4_bekle_yanit_yok", ust_yanit_gecerli_o, 0);
    alt_yanit_gecerli_i = 1'b1; alt_yanit_veri_i = VD;
    adim(); alt_yanit_gecerli_i = 1'b0;

    // response held while the cache stalls
    istek(32'h600, VX, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      kontrol("t5_tut_gecerli", ust_yanit_gecerli_o, 1);
      kontrol("t5_tut_veri", ust_yanit_veri_o, VD);
      kontrol("t5_tut_hazir", ust_istek_hazir_o, 0);
      adim();
    end
    birak();
    ust_yanit_hazir_i = 1'b1;
    adim();
    kontrol("t5_yanit_bitti", ust_yanit_gecerli_o, 0);
    kontrol("t5_doluluk", doluluk_o, 2);

    // reset during OKU_BEKLE with two entries queued
    istek(32'h040, VX, 1'b1); #1;
    kontrol("t6_yaz_hazir", ust_istek_hazir_o, 1);
    adim(); birak();
    kontrol("t6_doluluk3", doluluk_o, 3);
    istek(32'h700, '0, 1'b0);
    adim(); birak();
    alt_istek_hazir_i = 1'b1;
    adim();
    kontrol("t6_doluluk2", doluluk_o, 2);
    adim();
    kontrol("t6_oku_adres", alt_istek_adres_o, 32'h700);
    adim(); alt_istek_hazir_i = 1'b0;
    kontrol("t6_bekle", alt_yanit_hazir_o, 1);
    rst_i = 1'b1;
    adim();
    kontrol("t6_rst_hazir", ust_istek_hazir_o, 0);
    kontrol("t6_rst_yanit_gecerli", ust_yanit_gecerli_o, 0);
    kontrol("t6_rst_yanit_veri", ust_yanit_veri_o, 0);
    kontrol("t6_rst_alt_adres", alt_istek_adres_o, 0);
    kontrol("t6_rst_alt_veri", alt_istek_veri_o, 0);
    kontrol("t6_rst_alt_gecerli", alt_istek_gecerli_o, 0);
    kontrol("t6_rst_alt_yaz", alt_istek_yaz_gecerli_o, 0);
    kontrol("t6_rst_alt_yanit_hazir", alt_yanit_hazir_o, 0);
    kontrol("t6_rst_doluluk", doluluk_o, 0);
    rst_i = 1'b0;
    alt_yanit_gecerli_i = 1'b1; alt_yanit_veri_i = VE;
    repeat (2) adim();
    kontrol("t6_gec_yanit_gecerli", ust_yanit_gecerli_o, 0);
    kontrol("t6_gec_yanit_veri", ust_yanit_veri_o, 0);
    kontrol("t6_gec_alt_gecerli", alt_istek_gecerli_o, 0);
    kontrol("t6_gec_doluluk", doluluk_o, 0);
    alt_yanit_gecerli_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule
`default_nettype wire
